// File: rtl/word_bus_arbiter.sv
// word_bus_arbiter: round-robin owner of a shared word bus with bounded hold time per grant.
module word_bus_arbiter #(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 32,
  parameter int MAX_HOLD = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req,
  input  logic [N_REQ-1:0]             last,
  input  logic [N_REQ*WIDTH-1:0]       data_in,
  output logic [N_REQ-1:0]             gnt,
  output logic [$clog2(N_REQ)-1:0]     owner,
  output logic [WIDTH-1:0]             bus_out,
  output logic                         bus_valid,
  output logic                         timeout
);
  localparam int OW = $clog2(N_REQ);
  localparam int HW = $clog2(MAX_HOLD) + 1;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [OW-1:0]    owner_q, owner_d, rr_q, rr_d, sel, idx;
  logic [HW-1:0]    hold_q, hold_d;
  logic             granted, found, release_now;
  always_comb begin
    granted     = |gnt_q;
    bus_valid   = granted & req[owner_q];
    bus_out     = bus_valid ? data_in[owner_q*WIDTH +: WIDTH] : '0;
    timeout     = bus_valid & ~last[owner_q] & (hold_q == HW'(MAX_HOLD - 1));
    release_now = granted & (~req[owner_q] | (bus_valid & last[owner_q]) | timeout);
    sel   = '0;
    idx   = '0;
    found = 1'b0;
    // Scan from rr_ptr upward; the releasing owner sits last in this order.
    for (int k = 0; k < N_REQ; k++) begin
      idx = rr_q + OW'(k);
      if (!found && req[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    gnt_d   = gnt_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    hold_d  = hold_q + HW'(bus_valid);
    if (!granted || release_now) begin
      hold_d  = '0;
      gnt_d   = found ? N_REQ'(1) << sel : '0;
      owner_d = found ? sel : owner_q;
      rr_d    = found ? sel + OW'(1) : rr_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q   <= '0;
      owner_q <= '0;
      rr_q    <= '0;
      hold_q  <= '0;
    end else begin
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      hold_q  <= hold_d;
    end
  end
  assign gnt   = gnt_q;
  assign owner = owner_q;
endmodule

// File: tb/tb_word_bus_arbiter.sv
// tb_word_bus_arbiter: random and directed stimulus checked against a cycle-level reference model.
module tb_word_bus_arbiter;
  localparam int N = 4, W = 32, MH = 8;
  logic clk = 1'b0, rst;
  logic [N-1:0] req, last, gnt;
  logic [N*W-1:0] data_in;
  logic [1:0] owner;
  logic [W-1:0] bus_out;
  logic bus_valid, timeout;
  int errors = 0, checks = 0, tmo_seen = 0;
  int own = -1, rr = 0, beats = 0;

  word_bus_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .req(req), .last(last), .data_in(data_in),
    .gnt(gnt), .owner(owner), .bus_out(bus_out), .bus_valid(bus_valid), .timeout(timeout));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic [N-1:0] rq, input logic [N-1:0] ls);
    logic ev, et, rel;
    logic [W-1:0] eo;
    int nxt;
    rst = r;
    req = rq;
    last = ls;
    for (int i = 0; i < N; i++) data_in[i*W +: W] = $urandom;
    @(negedge clk);
    ev = (own >= 0) ? rq[own[1:0]] : 1'b0;
    eo = ev ? data_in[own*W +: W] : '0;
    et = ev && !ls[own[1:0]] && beats == MH - 1;
    check("gnt", 64'(gnt), (own < 0) ? 64'd0 : 64'd1 << own);
    if (own >= 0) check("owner", 64'(owner), 64'(own));
    check("bus_valid", 64'(bus_valid), 64'(ev));
    check("bus_out", 64'(bus_out), 64'(eo));
    check("timeout", 64'(timeout), 64'(et));
    if (timeout) tmo_seen++;
    if (r) begin
      own = -1; rr = 0; beats = 0;
    end else begin
      rel = own >= 0 && (!rq[own[1:0]] || (ev && ls[own[1:0]]) || et);
      if (own < 0 || rel) begin
        nxt = -1;
        for (int k = 0; k < N; k++) if (nxt < 0 && rq[(rr + k) % N]) nxt = (rr + k) % N;
        own = nxt;
        beats = 0;
        if (nxt >= 0) rr = (nxt + 1) % N;
      end else beats += int'(ev);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req = '0; last = '0; data_in = '0;
    @(posedge clk);
    #1;
    repeat (3) step(1'b1, 4'b0000, 4'b0000);
    repeat (3) step(1'b0, 4'b0101, 4'b0000);
    repeat (8) step(1'b0, 4'b1111, 4'b1111);
    repeat (4) step(1'b0, 4'b0011, 4'b0000);
    step(1'b0, 4'b0011, 4'b0001);
    step(1'b0, 4'b0010, 4'b0000);
    step(1'b1, 4'b0000, 4'b0000);
    tmo_seen = 0;
    repeat (17) step(1'b0, 4'b0010, 4'b0000);
    check("tmo_count", 64'(tmo_seen), 64'd2);
    repeat (3) step(1'b0, 4'b1101, 4'b0000);
    step(1'b0, 4'b1001, 4'b0000);
    repeat (3) step(1'b0, 4'b0010, 4'b0000);
    step(1'b1, 4'b0010, 4'b0000);
    repeat (3) step(1'b0, 4'b0011, 4'b0000);
    repeat (800) step($urandom_range(0, 63) == 0, N'($urandom), N'($urandom & $urandom));
    repeat (800) step($urandom_range(0, 127) == 0, N'($urandom | $urandom),
                      ($urandom_range(0, 15) == 0) ? N'($urandom) : 4'b0000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
